imem_loader: RTL

- Boot-time writer for the word-addressed instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word through a single-cycle write port at consecutive word addresses starting at 0, then verifies an XOR checksum.
- Holds the CPU in reset (`cpu_hold`) until a load completes cleanly. The memory's read port is otherwise untouched.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes, CSUM),
// packs the payload into little-endian 32-bit words and writes them to
// consecutive word addresses from 0. The CPU is held in reset until a load
// finishes with a matching XOR checksum.
module imem_loader #(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // Depth widened so the 16-bit length field can be compared without loss.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [1:0]        lane;
  logic [23:0]       wbuf;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        csum;

  logic              take;
  logic [15:0]       len_in;
  logic [ADDR_W:0]   word_nxt;
  logic              last_word;

  assign take      = in_valid & in_ready;
  assign len_in    = {in_data, len_lo};
  assign word_nxt  = word_cnt + 1'b1;
  // len never exceeds DEPTH once in DATA, so its low ADDR_W+1 bits suffice.
  assign last_word = (word_nxt == len[ADDR_W:0]);

  // Load sequencer: frame parsing, word assembly, memory write strobe and
  // registered status outputs. in_ready is set on every transition into a
  // byte-consuming state and cleared on every exit, so it never depends on
  // in_valid combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      word_cnt     <= '0;
      lane         <= '0;
      csum         <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            word_cnt     <= '0;
            lane         <= '0;
            csum         <= '0;
          end
        end
        S_LEN0: begin
          if (take) begin
            len_lo <= in_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (take) begin
            len <= len_in;
            if ({1'b0, len_in} > DEPTH_L) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else if (len_in == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            csum <= csum ^ in_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; the write port has no
                // backpressure, so byte acceptance never stalls here.
                mem_we       <= 1'b1;
                mem_addr     <= word_cnt[ADDR_W-1:0];
                mem_wdata    <= {in_data, wbuf};
                word_cnt     <= word_nxt;
                words_loaded <= word_nxt;
                if (last_word) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
          if (take) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
